dlock: RTL and testbench

Two-digit electronic combination lock controller. It takes a ten-key decimal keypad plus OPEN, CLOSE and SET buttons, holds a two-digit BCD password, and drives a LOCK output for the lock actuator. It sits between debounced front-panel buttons and the actuator driver. All buttons are level inputs synchronous to CLK, and each press acts exactly once.

---
 rtl/dlock_if.sv | 21 ++
 rtl/dlock.sv | 101 ++++++++++
 tb/tb_dlock.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dlock_if.sv
// Front-panel bundle for the combination lock: debounced keypad/control
// buttons toward the controller and the LOCK actuator drive back.
interface dlock_if;
    logic I0, I1, I2, I3, I4, I5, I6, I7, I8, I9;
    logic OPEN;
    logic CLOSE;
    logic SET;
    logic LOCK;

    modport master (
        output I0, I1, I2, I3, I4, I5, I6, I7, I8, I9,
        output OPEN, CLOSE, SET,
        input  LOCK
    );

    modport slave (
        input  I0, I1, I2, I3, I4, I5, I6, I7, I8, I9,
        input  OPEN, CLOSE, SET,
        output LOCK
    );
endinterface

// File: rtl/dlock.sv
// Two-digit combination lock: rising-edge button decode, shift-in BCD entry,
// stored password and a locked/unlocked state driving LOCK.
//
// state       | meaning
// ST_LOCKED   | actuator locked; SET ignored, OPEN unlocks on matching code
// ST_UNLOCKED | actuator released; SET stores the entry as new password
module dlock (
    input  logic   CLK,
    input  logic   RESET_N,
    dlock_if.slave bus
);
    typedef enum logic {ST_LOCKED = 1'b0, ST_UNLOCKED = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [12:0] btn, btn_prev, rise;
    logic [9:0]  key_rise;
    logic        key_single;
    logic [3:0]  key_val;
    logic        close_rise, open_rise, set_rise, ctrl_rise;
    logic [3:0]  digit1, digit2;
    logic [3:0]  pwd1, pwd2;
    logic        EQ;
    logic        lock_o;

    // bit order: [9:0] keys I9..I0, [10] SET, [11] OPEN, [12] CLOSE
    assign btn = {bus.CLOSE, bus.OPEN, bus.SET,
                  bus.I9, bus.I8, bus.I7, bus.I6, bus.I5,
                  bus.I4, bus.I3, bus.I2, bus.I1, bus.I0};

    assign rise       = btn & ~btn_prev;
    assign key_rise   = rise[9:0];
    assign set_rise   = rise[10];
    assign open_rise  = rise[11];
    assign close_rise = rise[12];
    assign ctrl_rise  = set_rise | open_rise | close_rise;

    // exactly one key edge this cycle; simultaneous keys are discarded
    assign key_single = (key_rise != 10'd0) && ((key_rise & (key_rise - 10'd1)) == 10'd0);

    always_comb begin
        key_val = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (key_rise[k]) key_val = 4'(k);
        end
    end

    assign EQ = ({digit1, digit2} == {pwd1, pwd2});

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            btn_prev <= 13'd0;
        end else begin
            btn_prev <= btn;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            digit1 <= 4'd0;
            digit2 <= 4'd0;
        end else if (!ctrl_rise && key_single) begin
            digit1 <= digit2;
            digit2 <= key_val;
        end
    end

    // SET acts only when neither higher-priority control button rose
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pwd1 <= 4'd0;
            pwd2 <= 4'd0;
        end else if (set_rise && !open_rise && !close_rise && state == ST_UNLOCKED) begin
            pwd1 <= digit1;
            pwd2 <= digit2;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_LOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (close_rise) begin
            state_nxt = ST_LOCKED;
        end else if (open_rise && EQ) begin
            state_nxt = ST_UNLOCKED;
        end
    end

    always_comb begin
        lock_o = 1'b1;
        if (state == ST_UNLOCKED) lock_o = 1'b0;
    end

    assign bus.LOCK = lock_o;
endmodule

// File: tb/tb_dlock.sv
// Directed bench for dlock: hand-computed expectations checked by
// immediate assertions after each step.
module tb_dlock;
    logic        CLK;
    logic        RESET_N;
    logic [12:0] btn;
    int          vectors;
    int          errs;

    localparam logic [12:0] B_SET   = 13'h0400;
    localparam logic [12:0] B_OPEN  = 13'h0800;
    localparam logic [12:0] B_CLOSE = 13'h1000;

    dlock_if bus ();

    assign bus.I0    = btn[0];
    assign bus.I1    = btn[1];
    assign bus.I2    = btn[2];
    assign bus.I3    = btn[3];
    assign bus.I4    = btn[4];
    assign bus.I5    = btn[5];
    assign bus.I6    = btn[6];
    assign bus.I7    = btn[7];
    assign bus.I8    = btn[8];
    assign bus.I9    = btn[9];
    assign bus.SET   = btn[10];
    assign bus.OPEN  = btn[11];
    assign bus.CLOSE = btn[12];

    dlock dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [12:0] key(input int k);
        logic [12:0] m;
        m = 13'd1;
        return m << k;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // hold the mask for 'hold' edges, then release for one edge
    task automatic press(input logic [12:0] m, input int hold);
        btn = m;
        repeat (hold) @(posedge CLK);
        #1;
        btn = 13'd0;
        @(posedge CLK);
        #1;
    endtask

    task automatic enter(input int a, input int b);
        press(key(a), 1);
        press(key(b), 1);
    endtask

    function automatic logic [7:0] digits();
        return {dut.digit1, dut.digit2};
    endfunction

    function automatic logic [7:0] pwd();
        return {dut.pwd1, dut.pwd2};
    endfunction

    initial begin
        vectors = 0;
        errs    = 0;
        btn     = 13'd0;
        RESET_N = 1'b0;
        #12;
        check("rst_lock", {7'd0, bus.LOCK}, 8'h01);
        check("rst_digits", digits(), 8'h00);
        check("rst_pwd", pwd(), 8'h00);
        check("rst_eq", {7'd0, dut.EQ}, 8'h01);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rel_lock", {7'd0, bus.LOCK}, 8'h01);
        check("rel_digits", digits(), 8'h00);
        check("rel_eq", {7'd0, dut.EQ}, 8'h01);

        // correct default code opens
        enter(0, 0);
        check("ok_digits", digits(), 8'h00);
        check("ok_eq", {7'd0, dut.EQ}, 8'h01);
        press(B_OPEN, 1);
        check("ok_open", {7'd0, bus.LOCK}, 8'h00);

        // new password while open
        enter(2, 5);
        check("chg_digits", digits(), 8'h25);
        check("chg_eq", {7'd0, dut.EQ}, 8'h00);
        press(B_SET, 1);
        check("chg_pwd", pwd(), 8'h25);
        check("chg_eq2", {7'd0, dut.EQ}, 8'h01);
        press(B_CLOSE, 1);
        check("chg_close", {7'd0, bus.LOCK}, 8'h01);

        // wrong code, SET while locked
        enter(0, 0);
        check("bad_digits", digits(), 8'h00);
        check("bad_eq", {7'd0, dut.EQ}, 8'h00);
        press(B_OPEN, 1);
        check("bad_open", {7'd0, bus.LOCK}, 8'h01);
        enter(7, 7);
        check("bad_digits77", digits(), 8'h77);
        press(B_SET, 1);
        check("bad_set", pwd(), 8'h25);
        press(B_CLOSE, 1);
        check("bad_close", {7'd0, bus.LOCK}, 8'h01);

        // holding a key shifts once
        press(key(3), 10);
        check("hold_key", digits(), 8'h73);

        // holding OPEN with matching code
        enter(2, 5);
        btn = B_OPEN;
        @(posedge CLK);
        #1;
        check("hold_open1", {7'd0, bus.LOCK}, 8'h00);
        repeat (4) @(posedge CLK);
        #1;
        check("hold_open5", {7'd0, bus.LOCK}, 8'h00);
        btn = 13'd0;
        @(posedge CLK);
        #1;

        // CLOSE beats OPEN
        press(B_OPEN | B_CLOSE, 1);
        check("pri_close", {7'd0, bus.LOCK}, 8'h01);

        // two keys together are discarded
        press(key(4) | key(6), 1);
        check("pri_2keys", digits(), 8'h25);

        // control edge suppresses key edge in the same cycle
        press(B_OPEN | key(9), 1);
        check("pri_ctl_lock", {7'd0, bus.LOCK}, 8'h00);
        check("pri_ctl_digits", digits(), 8'h25);

        // SET loses to OPEN in the same cycle
        enter(3, 1);
        press(B_OPEN | B_SET, 1);
        check("pri_open_set", pwd(), 8'h25);

        // reset while unlocked, I8 held through release
        btn = key(8);
        RESET_N = 1'b0;
        #2;
        check("mid_rst_lock", {7'd0, bus.LOCK}, 8'h01);
        check("mid_rst_pwd", pwd(), 8'h00);
        check("mid_rst_digits", digits(), 8'h00);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        check("held_thru_rst", digits(), 8'h08);
        btn = 13'd0;
        @(posedge CLK);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
